pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 182 ++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- two-entry skid buffer between pipeline stages.
//
// The buffer holds up to two entries: a main register and a skid register.
// Each entry is a control bundle plus a flat multi-channel payload. The head
// entry is always in main. When the stage is empty, the output control and
// payload are zero, so an empty slot looks like a bubble downstream. A flush
// kills every held entry and the same-cycle input. A bubble request blocks
// new input for that cycle, but the head can still drain.
//
// Ports
//   clk_i        : clock; all state changes on its rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid_i   : upstream presents an entry
//   in_ready_o   : buffer can take an entry (registered, low only when full)
//   ctrl_i       : upstream control bundle, CTRL_W bits
//   data_i       : upstream payload, channel k at [k*DATA_W +: DATA_W]
//   out_valid_o  : head entry valid
//   out_ready_i  : downstream takes the head entry
//   ctrl_o       : head control bundle, zero when out_valid_o is low
//   data_o       : head payload, zero when out_valid_o is low
//   flush_i      : kill all held and incoming entries
//   bubble_i     : refuse input this cycle
//
// Optional feature, macro PIPE_STAGE_PERF_EN:
//   stall_cnt_o  : saturating count of cycles with out_valid_o=1 and out_ready_i=0
//   bubble_cnt_o : saturating count of cycles with bubble_i=1 or flush_i=1

module pipe_stage_buf #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [CTRL_W-1:0]        ctrl_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CTRL_W-1:0]        ctrl_o,
  output logic [NUM_CH*DATA_W-1:0] data_o,
  input  logic                     flush_i,
  input  logic                     bubble_i
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]              stall_cnt_o,
  output logic [15:0]              bubble_cnt_o
`endif
);

  localparam int PAY_W = NUM_CH * DATA_W;
  localparam int ENT_W = CTRL_W + PAY_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [ENT_W-1:0]   main_r, main_nxt_s;
  logic [ENT_W-1:0]   skid_r, skid_nxt_s;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               acc_s;
  logic               tk_s;
  logic [ENT_W-1:0]   in_ent_s;

  assign in_ent_s = {ctrl_i, data_i};
  assign acc_s    = in_valid_i & in_ready_r & ~bubble_i & ~flush_i;
  assign tk_s     = out_valid_r & out_ready_i;

  // Next-state and register-content selection for the two-entry buffer.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (acc_s) begin
          main_nxt_s  = in_ent_s;
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (acc_s && tk_s) begin
          main_nxt_s  = in_ent_s;
          state_nxt_s = ST_ONE;
        end else if (acc_s) begin
          skid_nxt_s  = in_ent_s;
          state_nxt_s = ST_TWO;
        end else if (tk_s) begin
          // Clearing main keeps the outputs at zero while the stage is empty.
          main_nxt_s  = {ENT_W{1'b0}};
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (tk_s) begin
          main_nxt_s  = skid_r;
          skid_nxt_s  = {ENT_W{1'b0}};
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        main_nxt_s  = {ENT_W{1'b0}};
        skid_nxt_s  = {ENT_W{1'b0}};
        state_nxt_s = ST_EMPTY;
      end
    endcase
    // A flush overrides every other decision above.
    if (flush_i) begin
      main_nxt_s  = {ENT_W{1'b0}};
      skid_nxt_s  = {ENT_W{1'b0}};
      state_nxt_s = ST_EMPTY;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State, entry storage and registered handshake flags.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      main_r      <= {ENT_W{1'b0}};
      skid_r      <= {ENT_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      in_ready_r  <= (state_nxt_s != ST_TWO);
    end
  end

  // main is held at zero whenever the stage is empty, so it drives the outputs directly.
  assign out_valid_o = out_valid_r;
  assign in_ready_o  = in_ready_r;
  assign ctrl_o      = main_r[ENT_W-1:PAY_W];
  assign data_o      = main_r[PAY_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] bubble_cnt_r;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return val + 16'd1;
    end
  endfunction

  // Saturating performance counters for output stalls and bubble/flush cycles.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r  <= 16'd0;
      bubble_cnt_r <= 16'd0;
    end else begin
      if (out_valid_r && !out_ready_i) begin
        stall_cnt_r <= sat_inc16(stall_cnt_r);
      end
      if (bubble_i || flush_i) begin
        bubble_cnt_r <= sat_inc16(bubble_cnt_r);
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_r;
  assign bubble_cnt_o = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf. The reference model is a bounded
// FIFO (capacity two) held in queues; outputs are sampled 1 time unit after
// each rising edge.

module tb_pipe_stage_buf;

  localparam int CW = 11;
  localparam int DW = 16 * 5;

  logic          clk_i;
  logic          rst_n;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic          flush_i;
  logic          bubble_i;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt_o;
  logic [15:0]   bubble_cnt_o;
`endif

  pipe_stage_buf dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .flush_i     (flush_i),
    .bubble_i    (bubble_i)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO contents and the expected counter values.
  logic [CW-1:0] q_ctrl[$];
  logic [DW-1:0] q_data[$];
  int            stall_m  = 0;
  int            bubble_m = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ec = '0;
    ed = '0;
    if (q_ctrl.size() > 0) begin
      ec = q_ctrl[0];
      ed = q_data[0];
    end
    chk("out_valid", 128'(out_valid_o), 128'(q_ctrl.size() > 0));
    chk("in_ready",  128'(in_ready_o),  128'(q_ctrl.size() < 2));
    chk("ctrl",      128'(ctrl_o),      128'(ec));
    chk("data",      128'(data_o),      128'(ed));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt",  128'(stall_cnt_o),  128'(stall_m));
    chk("bubble_cnt", 128'(bubble_cnt_o), 128'(bubble_m));
`endif
  endtask

  // One clock cycle: drive the inputs, advance the model across the edge, then check.
  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic bub);
    bit acc;
    bit tk;
    in_valid_i  = v;
    ctrl_i      = c;
    data_i      = d;
    out_ready_i = ordy;
    flush_i     = fl;
    bubble_i    = bub;
    acc = v && (q_ctrl.size() < 2) && !bub && !fl;
    tk  = (q_ctrl.size() > 0) && ordy;
    if ((q_ctrl.size() > 0) && !ordy && stall_m < 65535) stall_m++;
    if ((bub || fl) && bubble_m < 65535) bubble_m++;
    @(posedge clk_i);
    if (fl) begin
      q_ctrl.delete();
      q_data.delete();
    end else begin
      if (tk) begin
        void'(q_ctrl.pop_front());
        void'(q_data.pop_front());
      end
      if (acc) begin
        q_ctrl.push_back(c);
        q_data.push_back(d);
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  logic [DW-1:0] da, db, dc;

  initial begin
    rst_n = 1'b0;
    in_valid_i = 1'b0; ctrl_i = '0; data_i = '0;
    out_ready_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
    #12;
    // Reset state.
    check_all();
    #1 rst_n = 1'b1;

    // First transfer after reset: one-cycle latency.
    da = '0;
    da[15:0] = 16'h1234;
    cycle(1'b1, 11'h7FF, da, 1'b1, 1'b0, 1'b0);
    chk("req038_valid", 128'(out_valid_o), 128'(1'b1));
    chk("req038_ctrl",  128'(ctrl_o),      128'(11'h7FF));
    chk("req038_ch0",   128'(data_o[15:0]), 128'(16'h1234));
    cycle(1'b0, 11'h000, '0, 1'b1, 1'b0, 1'b0);

    // Three offers with the consumer stalled: A and B held, C refused.
    da = rnd_data(); db = rnd_data(); dc = rnd_data();
    cycle(1'b1, 11'h0A1, da, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 11'h0B2, db, 1'b0, 1'b0, 1'b0);
    chk("req039_full", 128'(in_ready_o), 128'(1'b0));
    cycle(1'b1, 11'h0C3, dc, 1'b0, 1'b0, 1'b0);
    chk("req039_headA", 128'(data_o), 128'(da));
    cycle(1'b0, 11'h000, '0, 1'b1, 1'b0, 1'b0);
    chk("req039_headB", 128'(data_o), 128'(db));
    cycle(1'b0, 11'h000, '0, 1'b1, 1'b0, 1'b0);
    chk("req039_empty", 128'(out_valid_o), 128'(1'b0));

    // Flush while full, with a same-cycle input.
    cycle(1'b1, 11'h111, rnd_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 11'h222, rnd_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 11'h333, rnd_data(), 1'b0, 1'b1, 1'b0);
    chk("req040_valid", 128'(out_valid_o), 128'(1'b0));
    chk("req040_ctrl",  128'(ctrl_o),      128'(11'h000));
    chk("req040_data",  128'(data_o),      128'(0));
    chk("req040_ready", 128'(in_ready_o),  128'(1'b1));

    // Continuous stream with a two-cycle bubble.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 11'(i + 1), rnd_data(), 1'b1, 1'b0, (i == 3 || i == 4));
      if (i == 3 || i == 4) chk("req041_bubble_ctrl", 128'(ctrl_o), 128'(11'h000));
    end
    cycle(1'b0, 11'h000, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the FIFO model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 11'($urandom), rnd_data(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset pulse between edges while full.
    cycle(1'b0, 11'h000, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 11'h000, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 11'h155, rnd_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 11'h2AA, rnd_data(), 1'b0, 1'b0, 1'b0);
    chk("req042_full", 128'(in_ready_o), 128'(1'b0));
    in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
    #1 rst_n = 1'b0;
    q_ctrl.delete();
    q_data.delete();
    stall_m  = 0;
    bubble_m = 0;
    #1;
    check_all();
    chk("req042_valid", 128'(out_valid_o), 128'(1'b0));
    chk("req042_data",  128'(data_o),      128'(0));
    #1 rst_n = 1'b1;

    cycle(1'b1, 11'h3C3, rnd_data(), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 11'h000, '0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    // Long stall to reach counter saturation.
    cycle(1'b1, 11'h071, rnd_data(), 1'b0, 1'b0, 1'b0);
    repeat (70000) @(posedge clk_i);
    #1;
    stall_m = 65535;
    check_all();
    chk("req042_stall_sat", 128'(stall_cnt_o), 128'(16'hFFFF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
